volume_ramp: RTL

//  Multi-channel attenuator for the audio path, placed between the sample source and the DAC/I2S serializer.

---
 rtl/volume_ramp.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/volume_ramp.sv
// Multi-channel audio attenuator with zipper-free ramping.
// Each signed channel sample is shifted right arithmetically by the applied
// attenuation. Button edges move a target attenuation. The applied attenuation
// walks toward the target one step every ramp_samples_p accepted samples.
// Mute ramps the applied attenuation to max_atten_p and then forces zero output.
//
// Handshake: a transfer happens on any clock edge where valid and ready are
// both high. Upstream sees ready_o = ~valid_o | ready_i, so the single output
// register is refilled on the same cycle it drains. data_o and valid_o are held
// while downstream stalls.
module volume_ramp #(
    parameter int width_p        = 24,
    parameter int channels_p     = 2,
    parameter int min_atten_p    = 0,
    parameter int max_atten_p    = 7,
    parameter int reset_atten_p  = 3,
    parameter int ramp_samples_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 up_i,
    input  logic                                 down_i,
    input  logic                                 mute_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [channels_p*width_p-1:0]        data_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [channels_p*width_p-1:0]        data_o,
    output logic [$clog2(max_atten_p+1)-1:0]     atten_o,
    output logic                                 muted_o
);

    localparam int AW = $clog2(max_atten_p + 1);
    localparam int CW = (ramp_samples_p > 1) ? $clog2(ramp_samples_p) : 1;
    localparam int DW = channels_p * width_p;

    localparam logic [AW-1:0] MIN_A   = AW'(min_atten_p);
    localparam logic [AW-1:0] MAX_A   = AW'(max_atten_p);
    localparam logic [AW-1:0] RESET_A = AW'(reset_atten_p);
    localparam logic [CW-1:0] LAST_C  = CW'(ramp_samples_p - 1);

    // Button edge history and control state
    logic          up_prev_q, down_prev_q, mute_prev_q;
    logic          mute_q, mute_d;
    logic          muted_q, muted_d;
    logic [AW-1:0] target_q, target_d;
    logic [AW-1:0] atten_q, atten_d;
    logic [CW-1:0] count_q, count_d;

    // Data path state
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] shifted_w;

    logic          up_ev, down_ev, mute_ev;
    logic          accept;
    logic [AW-1:0] eff_target;

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign atten_o = atten_q;
    assign muted_o = muted_q;

    // Button events, target attenuation and mute state
    always_comb begin
        up_ev    = up_i & ~up_prev_q;
        down_ev  = down_i & ~down_prev_q;
        mute_ev  = mute_i & ~mute_prev_q;
        target_d = target_q;
        if (up_ev && !down_ev) begin
            if (target_q > MIN_A) target_d = target_q - 1'b1;
        end else if (down_ev && !up_ev) begin
            if (target_q < MAX_A) target_d = target_q + 1'b1;
        end
        mute_d = mute_q ^ mute_ev;
        // Output goes silent only once the ramp has reached the quietest step;
        // an unmute event drops it immediately.
        muted_d = mute_d & (atten_q == MAX_A);
    end

    // Applied-attenuation ramp: one step per ramp_samples_p accepted samples
    always_comb begin
        eff_target = mute_q ? MAX_A : target_q;
        atten_d    = atten_q;
        count_d    = count_q;
        if (atten_q == eff_target) begin
            count_d = '0;
        end else if (accept) begin
            if (count_q == LAST_C) begin
                count_d = '0;
                atten_d = (atten_q < eff_target) ? atten_q + 1'b1 : atten_q - 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Per-channel sign-preserving shift by the currently applied attenuation
    always_comb begin
        shifted_w = '0;
        for (int ch = 0; ch < channels_p; ch++) begin
            shifted_w[ch*width_p +: width_p] = $signed(data_i[ch*width_p +: width_p]) >>> atten_q;
        end
    end

    // Output register load / drain
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = muted_d ? '0 : shifted_w;
        end else if (ready_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // State registers, asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            mute_prev_q <= 1'b0;
            mute_q      <= 1'b0;
            muted_q     <= 1'b0;
            target_q    <= RESET_A;
            atten_q     <= RESET_A;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            up_prev_q   <= up_i;
            down_prev_q <= down_i;
            mute_prev_q <= mute_i;
            mute_q      <= mute_d;
            muted_q     <= muted_d;
            target_q    <= target_d;
            atten_q     <= atten_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

endmodule
